// File: rtl/timer_pkg.sv
// timer_pkg: shared encodings and control-word field layout for the 8253 access controller
package timer_pkg;
    localparam logic [1:0] RW_LATCH = 2'b00;
    localparam logic [1:0] RW_LSB = 2'b01;
    localparam logic [1:0] RW_MSB = 2'b10;
    localparam logic [1:0] RW_WORD = 2'b11;
    localparam logic [1:0] SC_ILLEGAL = 2'b11;
    localparam int CW_SC_LSB = 6;
    localparam int CW_RW_LSB = 4;
    localparam int CW_M_LSB = 1;
    localparam int CW_BCD_BIT = 0;
    localparam int MODE_W = 3;
    function automatic logic [MODE_W-1:0] fold_mode(input logic [MODE_W-1:0] m);
        return (m[2:1] == 2'b11) ? {1'b0, m[1:0]} : m;
    endfunction
endpackage

// File: rtl/timer_access_ctrl_if.sv
// timer_access_ctrl_if: decoder strobes and CPU data bus seen by the access controller
interface timer_access_ctrl_if;
    logic [3:0] ReadSignal;
    logic [3:0] WriteSignal;
    logic [7:0] D_IN;
    logic [7:0] D_OUT;
    logic D_OE;
    modport master (output ReadSignal, WriteSignal, D_IN, input D_OUT, D_OE);
    modport slave (input ReadSignal, WriteSignal, D_IN, output D_OUT, D_OE);
endinterface

// File: rtl/timer_access_chan.sv
// timer_access_chan: one counter's control word, byte pointers, count latch and LSB staging
module timer_access_chan
    import timer_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic cw_ev,
    input  logic [1:0] cw_rw,
    input  logic [MODE_W-1:0] cw_mode,
    input  logic cw_bcd,
    input  logic latch_ev,
    input  logic [15:0] cnt,
    input  logic wr_ev,
    input  logic [7:0] d,
    input  logic rd_done,
    output logic [1:0] rw,
    output logic [MODE_W-1:0] mode,
    output logic bcd,
    output logic load,
    output logic [15:0] load_val,
    output logic [7:0] rd_byte
);
    logic wr_ptr, rd_ptr, latched;
    logic [7:0] lsb;
    logic [15:0] latch_reg, src;
    logic [1:0] rw_n;
    logic [MODE_W-1:0] mode_n;
    logic bcd_n, wr_ptr_n, rd_ptr_n, latched_n;
    logic [7:0] lsb_n;
    logic [15:0] latch_reg_n;
    // state register for mode fields, pointers, latch and staged byte
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rw <= RW_LATCH;
            mode <= '0;
            bcd <= 1'b0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            latched <= 1'b0;
            lsb <= 8'h00;
            latch_reg <= 16'h0000;
        end else begin
            rw <= rw_n;
            mode <= mode_n;
            bcd <= bcd_n;
            wr_ptr <= wr_ptr_n;
            rd_ptr <= rd_ptr_n;
            latched <= latched_n;
            lsb <= lsb_n;
            latch_reg <= latch_reg_n;
        end
    end
    // next state: read completion, byte writes, latch command; a new control word overrides all
    always_comb begin
        rw_n = rw;
        mode_n = mode;
        bcd_n = bcd;
        wr_ptr_n = wr_ptr;
        rd_ptr_n = rd_ptr;
        latched_n = latched;
        lsb_n = lsb;
        latch_reg_n = latch_reg;
        if (rd_done && rw == RW_WORD) begin
            rd_ptr_n = ~rd_ptr;
            latched_n = rd_ptr ? 1'b0 : latched;
        end else if (rd_done && rw != RW_LATCH) begin
            latched_n = 1'b0;
        end
        if (wr_ev && rw == RW_WORD) begin
            wr_ptr_n = ~wr_ptr;
            lsb_n = wr_ptr ? lsb : d;
        end
        if (latch_ev && !latched) begin
            latch_reg_n = cnt;
            latched_n = 1'b1;
        end
        if (cw_ev) begin
            rw_n = cw_rw;
            mode_n = cw_mode;
            bcd_n = cw_bcd;
            wr_ptr_n = 1'b0;
            rd_ptr_n = 1'b0;
            latched_n = 1'b0;
            lsb_n = 8'h00;
        end
    end
    assign load = wr_ev && (rw == RW_LSB || rw == RW_MSB || (rw == RW_WORD && wr_ptr));
    assign load_val = (rw == RW_LSB) ? {8'h00, d} : (rw == RW_MSB) ? {d, 8'h00} : {d, lsb};
    assign src = latched ? latch_reg : cnt;
    assign rd_byte = (rw == RW_LSB) ? src[7:0] :
                     (rw == RW_MSB) ? src[15:8] :
                     (rw == RW_WORD) ? (rd_ptr ? src[15:8] : src[7:0]) : 8'h00;
endmodule

// File: rtl/timer_access_ctrl.sv
// timer_access_ctrl: bus-side control word, load and readback sequencing for three 8253 counters
module timer_access_ctrl
    import timer_pkg::*;
(
    input  logic CLK,
    input  logic RST_N,
    timer_access_ctrl_if.slave bus,
    input  logic [15:0] CNT0,
    input  logic [15:0] CNT1,
    input  logic [15:0] CNT2,
    output logic [2:0] LOAD,
    output logic [15:0] LOAD_VAL,
    output logic [2:0] CW_STB,
    output logic [MODE_W-1:0] MODE0,
    output logic [MODE_W-1:0] MODE1,
    output logic [MODE_W-1:0] MODE2,
    output logic [2:0] BCD,
    output logic [1:0] RW0,
    output logic [1:0] RW1,
    output logic [1:0] RW2
);
    logic [3:0] wr_s1, wr_s2, wr_ev;
    logic [2:0] rd_s1, rd_s2, rd_done, prog, latch, ld;
    logic [7:0] d_q, d_out, sel;
    logic d_oe, cw_ok, read_ok;
    logic [1:0] sc, cw_rw;
    logic [MODE_W-1:0] cw_mode;
    logic [15:0] cnt [3];
    logic [15:0] lv [3];
    logic [7:0] rb [3];
    logic [1:0] rw_a [3];
    logic [MODE_W-1:0] mode_a [3];
    // registered strobe and data copies for edge detection; reads are masked while any write is active
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_s1 <= '0;
            wr_s2 <= '0;
            rd_s1 <= '0;
            rd_s2 <= '0;
            d_q <= 8'h00;
        end else begin
            wr_s1 <= bus.WriteSignal;
            wr_s2 <= wr_s1;
            rd_s1 <= (|bus.WriteSignal) ? 3'b000 : bus.ReadSignal[2:0];
            rd_s2 <= rd_s1;
            d_q <= bus.D_IN;
        end
    end
    assign wr_ev = wr_s1 & ~wr_s2;
    assign rd_done = rd_s2 & ~rd_s1;
    assign sc = d_q[CW_SC_LSB +: 2];
    assign cw_rw = d_q[CW_RW_LSB +: 2];
    assign cw_mode = fold_mode(d_q[CW_M_LSB +: MODE_W]);
    assign cw_ok = wr_ev[3] && sc != SC_ILLEGAL;
    assign cnt[0] = CNT0;
    assign cnt[1] = CNT1;
    assign cnt[2] = CNT2;
    for (genvar i = 0; i < 3; i++) begin : g_chan
        assign prog[i] = cw_ok && sc == 2'(i) && cw_rw != RW_LATCH;
        assign latch[i] = cw_ok && sc == 2'(i) && cw_rw == RW_LATCH;
        timer_access_chan u_chan (
            .clk(CLK),
            .rst_n(RST_N),
            .cw_ev(prog[i]),
            .cw_rw(cw_rw),
            .cw_mode(cw_mode),
            .cw_bcd(d_q[CW_BCD_BIT]),
            .latch_ev(latch[i]),
            .cnt(cnt[i]),
            .wr_ev(wr_ev[i]),
            .d(d_q),
            .rd_done(rd_done[i]),
            .rw(rw_a[i]),
            .mode(mode_a[i]),
            .bcd(BCD[i]),
            .load(ld[i]),
            .load_val(lv[i]),
            .rd_byte(rb[i])
        );
    end
    assign read_ok = |bus.ReadSignal[2:0] && !(|bus.WriteSignal);
    assign sel = bus.ReadSignal[0] ? rb[0] : bus.ReadSignal[1] ? rb[1] : rb[2];
    // one-cycle strobes, load value capture and registered read data
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            LOAD <= '0;
            LOAD_VAL <= 16'h0000;
            CW_STB <= '0;
            d_out <= 8'h00;
            d_oe <= 1'b0;
        end else begin
            LOAD <= ld;
            LOAD_VAL <= (|ld) ? (ld[0] ? lv[0] : ld[1] ? lv[1] : lv[2]) : LOAD_VAL;
            CW_STB <= prog;
            d_out <= read_ok ? sel : 8'h00;
            d_oe <= read_ok;
        end
    end
    assign bus.D_OUT = d_out;
    assign bus.D_OE = d_oe;
    assign MODE0 = mode_a[0];
    assign MODE1 = mode_a[1];
    assign MODE2 = mode_a[2];
    assign RW0 = rw_a[0];
    assign RW1 = rw_a[1];
    assign RW2 = rw_a[2];
endmodule

// File: tb/tb_timer_access_ctrl.sv
// tb_timer_access_ctrl: directed vectors and corner sequences for timer_access_ctrl
module tb_timer_access_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [15:0] cnt0 = 16'h0, cnt1 = 16'h0, cnt2 = 16'h0;
    logic [2:0] load, cw_stb, bcd;
    logic [15:0] load_val;
    logic [2:0] mode0, mode1, mode2;
    logic [1:0] rw0, rw1, rw2;
    int pass_n = 0;
    int total_n = 0;
    timer_access_ctrl_if bus();
    timer_access_ctrl dut (
        .CLK(clk), .RST_N(rst_n), .bus(bus),
        .CNT0(cnt0), .CNT1(cnt1), .CNT2(cnt2),
        .LOAD(load), .LOAD_VAL(load_val), .CW_STB(cw_stb),
        .MODE0(mode0), .MODE1(mode1), .MODE2(mode2), .BCD(bcd),
        .RW0(rw0), .RW1(rw1), .RW2(rw2)
    );
    always #5 clk = ~clk;
    typedef struct {
        string name;
        logic [3:0] ws;
        logic [7:0] d;
        logic [2:0] ld;
        logic [15:0] lv;
        logic [2:0] cs;
    } vec_t;
    vec_t vec [12];
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_n++;
        if (act === exp) pass_n++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask
    task automatic wr_op(input logic [3:0] ws, input logic [7:0] d, output logic [2:0] ld,
                         output logic [15:0] lv, output logic [2:0] cs, output int nld,
                         output int ncs, output int ld_idx, output int cs_idx);
        ld = '0; lv = '0; cs = '0; nld = 0; ncs = 0; ld_idx = -1; cs_idx = -1;
        @(negedge clk);
        bus.WriteSignal = ws;
        bus.D_IN = d;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (load != 0) begin
                nld++; ld |= load; lv = load_val;
                if (ld_idx < 0) ld_idx = k;
            end
            if (cw_stb != 0) begin
                ncs++; cs |= cw_stb;
                if (cs_idx < 0) cs_idx = k;
            end
            if (k == 2) bus.WriteSignal = 4'b0000;
        end
    endtask
    task automatic run_vec(input vec_t v);
        logic [2:0] ld, cs;
        logic [15:0] lv;
        int nld, ncs, ldi, csi;
        wr_op(v.ws, v.d, ld, lv, cs, nld, ncs, ldi, csi);
        check({v.name, " load"}, 32'(ld), 32'(v.ld));
        check({v.name, " load pulses"}, 32'(nld), (v.ld != 0) ? 32'd1 : 32'd0);
        check({v.name, " cw_stb"}, 32'(cs), 32'(v.cs));
        check({v.name, " cw_stb pulses"}, 32'(ncs), (v.cs != 0) ? 32'd1 : 32'd0);
        if (v.ld != 0) begin
            check({v.name, " load_val"}, 32'(lv), 32'(v.lv));
            check({v.name, " load latency"}, 32'(ldi), 32'd1);
        end
        if (v.cs != 0) check({v.name, " cw_stb latency"}, 32'(csi), 32'd1);
    endtask
    task automatic rd_op(input logic [3:0] rs, output logic [7:0] b, output logic oe);
        @(negedge clk);
        bus.ReadSignal = rs;
        @(negedge clk);
        b = bus.D_OUT;
        oe = bus.D_OE;
        bus.ReadSignal = 4'b0000;
        repeat (3) @(negedge clk);
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
    initial begin
        logic [7:0] b;
        logic oe, seen_oe;
        logic [2:0] ld;
        logic [15:0] lv;
        bus.ReadSignal = 4'b0000;
        bus.WriteSignal = 4'b0000;
        bus.D_IN = 8'h00;
        vec[0]  = '{"cw34", 4'b1000, 8'h34, 3'b000, 16'h0000, 3'b001};
        vec[1]  = '{"w0 E8", 4'b0001, 8'hE8, 3'b000, 16'h0000, 3'b000};
        vec[2]  = '{"w0 03", 4'b0001, 8'h03, 3'b001, 16'h03E8, 3'b000};
        vec[3]  = '{"cw50", 4'b1000, 8'h50, 3'b000, 16'h0000, 3'b010};
        vec[4]  = '{"w1 7F", 4'b0010, 8'h7F, 3'b010, 16'h007F, 3'b000};
        vec[5]  = '{"cw9E", 4'b1000, 8'h9E, 3'b000, 16'h0000, 3'b100};
        vec[6]  = '{"cwF4", 4'b1000, 8'hF4, 3'b000, 16'h0000, 3'b000};
        vec[7]  = '{"cw34 b", 4'b1000, 8'h34, 3'b000, 16'h0000, 3'b001};
        vec[8]  = '{"w0 E8 b", 4'b0001, 8'hE8, 3'b000, 16'h0000, 3'b000};
        vec[9]  = '{"cw34 mid", 4'b1000, 8'h34, 3'b000, 16'h0000, 3'b001};
        vec[10] = '{"w0 55", 4'b0001, 8'h55, 3'b000, 16'h0000, 3'b000};
        vec[11] = '{"w0 66", 4'b0001, 8'h66, 3'b001, 16'h6655, 3'b000};
        repeat (3) @(negedge clk);
        check("reset strobes", 32'({load, cw_stb, load_val}), 32'd0);
        check("reset modes", 32'({mode0, mode1, mode2, bcd}), 32'd0);
        check("reset rw", 32'({rw0, rw1, rw2}), 32'd0);
        check("reset dout", 32'({bus.D_OUT, bus.D_OE}), 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) run_vec(vec[i]);
        check("rw0", 32'(rw0), 32'd3);
        check("mode0", 32'(mode0), 32'd2);
        check("rw1", 32'(rw1), 32'd1);
        check("mode1", 32'(mode1), 32'd0);
        check("rw2", 32'(rw2), 32'd1);
        check("mode2 folded", 32'(mode2), 32'd3);
        check("bcd", 32'(bcd), 32'd0);
        cnt0 = 16'h1234;
        run_vec('{"latch0", 4'b1000, 8'h00, 3'b000, 16'h0000, 3'b000});
        cnt0 = 16'h1200;
        run_vec('{"latch0 again", 4'b1000, 8'h00, 3'b000, 16'h0000, 3'b000});
        check("rw0 after latch", 32'(rw0), 32'd3);
        rd_op(4'b0001, b, oe);
        check("latched lsb", 32'(b), 32'h34);
        check("read oe", 32'(oe), 32'd1);
        check("oe after read", 32'(bus.D_OE), 32'd0);
        rd_op(4'b0001, b, oe);
        check("latched msb", 32'(b), 32'h12);
        rd_op(4'b0001, b, oe);
        check("live lsb", 32'(b), 32'h00);
        cnt1 = 16'h00AB;
        @(negedge clk);
        bus.ReadSignal = 4'b0010;
        @(negedge clk);
        check("live track 1", 32'(bus.D_OUT), 32'hAB);
        cnt1 = 16'h00CD;
        @(negedge clk);
        check("live track 2", 32'(bus.D_OUT), 32'hCD);
        bus.ReadSignal = 4'b0000;
        repeat (3) @(negedge clk);
        seen_oe = 1'b0; ld = '0; lv = '0;
        bus.ReadSignal = 4'b0001;
        bus.WriteSignal = 4'b0010;
        bus.D_IN = 8'h22;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            seen_oe |= bus.D_OE;
            if (load != 0) begin ld |= load; lv = load_val; end
            if (k == 2) begin bus.ReadSignal = 4'b0000; bus.WriteSignal = 4'b0000; end
        end
        check("conflict oe", 32'(seen_oe), 32'd0);
        check("conflict load", 32'(ld), 32'd2);
        check("conflict load_val", 32'(lv), 32'h0022);
        run_vec('{"cw34 pre-rst", 4'b1000, 8'h34, 3'b000, 16'h0000, 3'b001});
        run_vec('{"w0 E8 pre-rst", 4'b0001, 8'hE8, 3'b000, 16'h0000, 3'b000});
        rst_n = 1'b0;
        @(negedge clk);
        check("rst rw0", 32'(rw0), 32'd0);
        check("rst mode0", 32'(mode0), 32'd0);
        check("rst load_val", 32'(load_val), 32'd0);
        check("rst strobes", 32'({load, cw_stb, bus.D_OE}), 32'd0);
        rst_n = 1'b1;
        run_vec('{"w0 rw00", 4'b0001, 8'h77, 3'b000, 16'h0000, 3'b000});
        check("rw0 still 00", 32'(rw0), 32'd0);
        run_vec('{"cw34 post-rst", 4'b1000, 8'h34, 3'b000, 16'h0000, 3'b001});
        run_vec('{"w0 99", 4'b0001, 8'h99, 3'b000, 16'h0000, 3'b000});
        run_vec('{"w0 11", 4'b0001, 8'h11, 3'b001, 16'h1199, 3'b000});
        $display("%0d/%0d checks passed", pass_n, total_n);
        $finish;
    end
endmodule
